// File: rtl/conversor_bcd.sv
// Sequential signed-binary to packed-BCD converter for the seven-segment display.
// Iterative double-dabble (one bit per clock), then overflow check and leading-zero blanking.
module conversor_bcd #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned DIGITS = 6
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             start,
  input  logic [WIDTH-1:0] valor,
  output logic [31:0]      segmentos,
  output logic             neg,
  output logic             ovf,
  output logic             busy,
  output logic             done
);

  localparam int unsigned ND = (WIDTH * 3) / 10 + 1;
  localparam int unsigned BW = ND * 4;
  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, FORMAT} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] mag_q, mag_d;
  logic [BW-1:0]    bcd_q, bcd_d;
  logic             sign_q, sign_d;
  logic [31:0]      seg_q, seg_d;
  logic             neg_q, neg_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;

  logic [BW-1:0]       bcd_adj;
  logic [BW+WIDTH-1:0] shreg;
  logic [31:0]         fmt;
  logic                any_hi;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (cnt_q == CW'(WIDTH - 1)) state_d = FORMAT;
      FORMAT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Add-3 correction on every digit, then shift the combined {bcd, mag} register.
  always_comb begin
    bcd_adj = bcd_q;
    for (int unsigned i = 0; i < ND; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    shreg = {bcd_adj, mag_q} << 1;
  end

  // Blank leading zeros from the top displayed digit down; digit 0 always shows.
  always_comb begin
    logic        lead;
    logic [3:0]  dig;
    int unsigned idx;
    any_hi = 1'b0;
    fmt    = '1;
    lead   = 1'b1;
    dig    = '0;
    idx    = 0;
    for (int unsigned i = 0; i < ND; i++) begin
      if (i >= DIGITS && bcd_q[4*i +: 4] != 4'd0) any_hi = 1'b1;
    end
    for (int unsigned k = 0; k < DIGITS; k++) begin
      idx = DIGITS - 1 - k;
      dig = (idx < ND) ? bcd_q[4*idx +: 4] : 4'd0;
      if (!(lead && dig == 4'd0 && idx != 0)) begin
        lead = 1'b0;
        fmt[4*idx +: 4] = dig;
      end
    end
  end

  always_comb begin
    cnt_d  = cnt_q;
    mag_d  = mag_q;
    bcd_d  = bcd_q;
    sign_d = sign_q;
    seg_d  = seg_q;
    neg_d  = neg_q;
    ovf_d  = ovf_q;
    done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          sign_d = valor[WIDTH-1];
          mag_d  = valor[WIDTH-1] ? (~valor + WIDTH'(1)) : valor;
          bcd_d  = '0;
          cnt_d  = '0;
        end
      end
      SHIFT: begin
        {bcd_d, mag_d} = shreg;
        cnt_d          = cnt_q + CW'(1);
      end
      FORMAT: begin
        ovf_d  = any_hi;
        seg_d  = any_hi ? '1 : fmt;
        neg_d  = sign_q;
        done_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cnt_q  <= '0;
      mag_q  <= '0;
      bcd_q  <= '0;
      sign_q <= 1'b0;
      seg_q  <= 32'hFFFF_FFF0;
      neg_q  <= 1'b0;
      ovf_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      mag_q  <= mag_d;
      bcd_q  <= bcd_d;
      sign_q <= sign_d;
      seg_q  <= seg_d;
      neg_q  <= neg_d;
      ovf_q  <= ovf_d;
      done_q <= done_d;
    end
  end

  always_comb begin
    busy      = (state_q != IDLE);
    segmentos = seg_q;
    neg       = neg_q;
    ovf       = ovf_q;
    done      = done_q;
  end

endmodule
